// File: rtl/accum_pkg.sv
// accum_pkg: shared state type and constants for accum_reader.
package accum_pkg;
  localparam int ACC_W = 32;
  localparam logic signed [ACC_W-1:0] INT8_MIN = -32'sd128;
  localparam logic signed [ACC_W-1:0] INT8_MAX = 32'sd127;
  typedef enum logic [2:0] {IDLE, ACCUM, READ, CAPT, DONE} state_e;
endpackage

// File: rtl/result_fifo.sv
// result_fifo: synchronous FIFO with registered head; valid rises the cycle after a push.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign valid_o = cnt_q != '0;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    do_pop  = pop_i && valid_o;
    do_push = push_i && (!full_o || do_pop);
    if (do_push) begin
      mem_d[wr_q] = data_i;
      wr_d = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/accum_reader.sv
// accum_reader: sequences psums into the accumulator, reads each output into a result FIFO.
// Optional ACCUM_READER_CLAMP_EN clamps captured results to signed int8 range.
module accum_reader
  import accum_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_psum_i,
  input  logic [CNT_W-1:0] num_out_i,
  input  logic             psum_valid_i,
  input  logic [31:0]      psum_i,
  output logic             psum_ready_o,
  output logic             acc_write_en_o,
  output logic [31:0]      acc_data_o,
  output logic             acc_read_en_o,
  input  logic [31:0]      acc_data_i,
  output logic             res_valid_o,
  output logic [31:0]      res_data_o,
  input  logic             res_ready_i,
  output logic             busy_o,
  output logic             done_o
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] psum_cnt_q, psum_cnt_d, out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] num_psum_q, num_psum_d, num_out_q, num_out_d;
  logic [CNT_W-1:0] psum_inc, out_inc;
  logic [ACC_W-1:0] push_data;
  logic push, fifo_full;
  assign psum_inc       = psum_cnt_q + 1'b1;
  assign out_inc        = out_cnt_q + 1'b1;
  assign acc_write_en_o = psum_valid_i & psum_ready_o;
  assign acc_data_o     = psum_ready_o ? psum_i : '0;
  assign busy_o         = state_q != IDLE;
`ifdef ACCUM_READER_CLAMP_EN
  assign push_data = ($signed(acc_data_i) < INT8_MIN) ? INT8_MIN :
                     ($signed(acc_data_i) > INT8_MAX) ? INT8_MAX : acc_data_i;
`else
  assign push_data = acc_data_i;
`endif
  always_comb begin
    state_d       = state_q;
    psum_cnt_d    = psum_cnt_q;
    out_cnt_d     = out_cnt_q;
    num_psum_d    = num_psum_q;
    num_out_d     = num_out_q;
    psum_ready_o  = 1'b0;
    acc_read_en_o = 1'b0;
    push          = 1'b0;
    done_o        = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        num_psum_d = (num_psum_i == '0) ? CNT_W'(1) : num_psum_i;
        num_out_d  = num_out_i;
        psum_cnt_d = '0;
        out_cnt_d  = '0;
        state_d    = (num_out_i == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        psum_ready_o = 1'b1;
        if (psum_valid_i) begin
          psum_cnt_d = psum_inc;
          if (psum_inc == num_psum_q) state_d = READ;
        end
      end
      READ: if (!fifo_full) begin
        acc_read_en_o = 1'b1;
        state_d       = CAPT;
      end
      CAPT: begin
        push       = 1'b1;
        out_cnt_d  = out_inc;
        psum_cnt_d = '0;
        state_d    = (out_inc == num_out_q) ? DONE : ACCUM;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      psum_cnt_q <= '0;
      out_cnt_q  <= '0;
      num_psum_q <= '0;
      num_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      psum_cnt_q <= psum_cnt_d;
      out_cnt_q  <= out_cnt_d;
      num_psum_q <= num_psum_d;
      num_out_q  <= num_out_d;
    end
  end
  result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ACC_W)) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .data_i (push_data),
    .pop_i  (res_ready_i),
    .full_o (fifo_full),
    .valid_o(res_valid_o),
    .data_o (res_data_o)
  );
endmodule

// File: tb/tb_accum_reader.sv
// tb_accum_reader: directed tests for accum_reader with a behavioural accumulator model.
module tb_accum_reader;
  logic clk = 1'b0;
  logic rst_i = 1'b1, start_i = 1'b0, psum_valid_i = 1'b0, res_ready_i = 1'b0;
  logic [7:0] num_psum_i = '0, num_out_i = '0;
  logic [31:0] psum_i = '0, acc_data_i, acc_data_o, res_data_o;
  logic psum_ready_o, acc_write_en_o, acc_read_en_o, res_valid_o, busy_o, done_o;
  int checks = 0, fails = 0;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, excl = 0;
  logic [31:0] got[$];
  logic [31:0] acc_sum, zp = '0;

  accum_reader #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .num_psum_i(num_psum_i),
    .num_out_i(num_out_i), .psum_valid_i(psum_valid_i), .psum_i(psum_i),
    .psum_ready_o(psum_ready_o), .acc_write_en_o(acc_write_en_o), .acc_data_o(acc_data_o),
    .acc_read_en_o(acc_read_en_o), .acc_data_i(acc_data_i), .res_valid_o(res_valid_o),
    .res_data_o(res_data_o), .res_ready_i(res_ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_i) begin
      acc_sum    <= zp;
      acc_data_i <= '0;
    end else if (acc_read_en_o) begin
      acc_data_i <= acc_sum;
      acc_sum    <= zp;
    end else if (acc_write_en_o) begin
      acc_sum <= acc_sum + acc_data_o;
    end
  end

  always @(negedge clk) begin
    if (acc_write_en_o) wr_cnt++;
    if (acc_read_en_o) rd_cnt++;
    if (done_o) done_cnt++;
    if (acc_write_en_o && acc_read_en_o) excl++;
    if (res_valid_o && res_ready_i) got.push_back(res_data_o);
  end

  task automatic do_reset;
    rst_i = 1'b1;
    start_i = 1'b0;
    psum_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic start_tile(input logic [7:0] np, input logic [7:0] no);
    num_psum_i = np;
    num_out_i = no;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic send_psum(input logic [31:0] v);
    bit ok = 1'b0;
    int n = 0;
    psum_valid_i = 1'b1;
    psum_i = v;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = psum_ready_o;
      @(posedge clk);
      #1 n++;
    end
    psum_valid_i = 1'b0;
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL psum_accept: value %0d accepted=%0b, required 1 within 200 cycles", v, ok);
    end
  endtask

  task automatic wait_results(input int n);
    int k = 0;
    while (got.size() < n && k < 200) begin
      @(posedge clk);
      #1 k++;
    end
    checks++;
    if (got.size() < n) begin
      fails++;
      $display("FAIL result_timeout: got %0d results, required %0d", got.size(), n);
    end
  endtask

  task automatic test_reset;
    zp = '0;
    do_reset();
    res_ready_i = 1'b0;
    start_tile(8'd1, 8'd1);
    send_psum(32'd42);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (res_valid_o !== 1'b1 || res_data_o !== 32'd42) begin
      fails++;
      $display("FAIL reset_pre_result: valid=%0b data=%0d, required 1/42", res_valid_o, res_data_o);
    end
    @(posedge clk);
    #1;
    start_tile(8'd3, 8'd2);
    send_psum(32'd1);
    send_psum(32'd2);
    rst_i = 1'b1;
    psum_valid_i = 1'b1;
    psum_i = 32'd99;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({psum_ready_o, acc_write_en_o, acc_read_en_o, res_valid_o, busy_o, done_o} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: rdy/we/re/rv/busy/done=%06b, required 000000",
               {psum_ready_o, acc_write_en_o, acc_read_en_o, res_valid_o, busy_o, done_o});
    end
    checks++;
    if (acc_data_o !== 32'd0 || res_data_o !== 32'd0) begin
      fails++;
      $display("FAIL reset_data: acc_data=%0h res_data=%0h, required 0/0", acc_data_o, res_data_o);
    end
    @(posedge clk);
    #1 rst_i = 1'b0;
    psum_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || res_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: busy=%0b res_valid=%0b, required 0/0", busy_o, res_valid_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    int wr0, rd0, dn0, base;
    zp = 32'd5;
    res_ready_i = 1'b1;
    do_reset();
    wr0 = wr_cnt; rd0 = rd_cnt; dn0 = done_cnt; base = got.size();
    start_tile(8'd3, 8'd1);
    send_psum(32'd10);
    repeat (2) @(posedge clk);
    #1;
    send_psum(32'd20);
    @(posedge clk);
    #1;
    send_psum(32'd30);
    @(negedge clk);
    checks++;
    if (acc_read_en_o !== 1'b1 || acc_write_en_o !== 1'b0) begin
      fails++;
      $display("FAIL single_read_t1: re=%0b we=%0b, required 1/0", acc_read_en_o, acc_write_en_o);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (res_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      fails++;
      $display("FAIL single_capt_t2: res_valid=%0b busy=%0b, required 0/1", res_valid_o, busy_o);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (res_valid_o !== 1'b1 || res_data_o !== 32'd65 || done_o !== 1'b1) begin
      fails++;
      $display("FAIL single_t3: res_valid=%0b data=%0d done=%0b, required 1/65/1",
               res_valid_o, res_data_o, done_o);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got.size() != base + 1 || got[base] !== 32'd65) begin
      fails++;
      $display("FAIL single_result: count=%0d first=%0d, required %0d/65", got.size(), got[base], base + 1);
    end
    checks++;
    if (wr_cnt - wr0 != 3 || rd_cnt - rd0 != 1 || done_cnt - dn0 != 1) begin
      fails++;
      $display("FAIL single_counts: writes=%0d reads=%0d dones=%0d, required 3/1/1",
               wr_cnt - wr0, rd_cnt - rd0, done_cnt - dn0);
    end
    zp = '0;
  endtask

  task automatic test_zero_outputs;
    int wr0, rd0;
    do_reset();
    wr0 = wr_cnt; rd0 = rd_cnt;
    start_tile(8'd5, 8'd0);
    @(negedge clk);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b1) begin
      fails++;
      $display("FAIL zero_done: done=%0b busy=%0b, required 1/1", done_o, busy_o);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || res_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL zero_after: done=%0b busy=%0b res_valid=%0b, required 0/0/0", done_o, busy_o, res_valid_o);
    end
    checks++;
    if (wr_cnt - wr0 != 0 || rd_cnt - rd0 != 0) begin
      fails++;
      $display("FAIL zero_acc_activity: writes=%0d reads=%0d, required 0/0", wr_cnt - wr0, rd_cnt - rd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure;
    int rd0, dn0, base;
    do_reset();
    res_ready_i = 1'b0;
    rd0 = rd_cnt; dn0 = done_cnt; base = got.size();
    start_tile(8'd1, 8'd6);
    for (int i = 1; i <= 5; i++) send_psum(32'(i));
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (psum_ready_o !== 1'b0 || acc_read_en_o !== 1'b0 || busy_o !== 1'b1 || res_valid_o !== 1'b1) begin
      fails++;
      $display("FAIL bp_stall: rdy=%0b re=%0b busy=%0b rv=%0b, required 0/0/1/1",
               psum_ready_o, acc_read_en_o, busy_o, res_valid_o);
    end
    checks++;
    if (rd_cnt - rd0 != 4 || got.size() != base) begin
      fails++;
      $display("FAIL bp_queued: reads=%0d popped=%0d, required 4/0", rd_cnt - rd0, got.size() - base);
    end
    @(posedge clk);
    #1 res_ready_i = 1'b1;
    send_psum(32'd6);
    wait_results(base + 6);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got.size() <= base + i || got[base+i] !== 32'(i + 1)) begin
        fails++;
        $display("FAIL bp_order[%0d]: got %0d, required %0d", i,
                 (got.size() > base + i) ? got[base+i] : 32'hx, i + 1);
      end
    end
    checks++;
    if (done_cnt - dn0 != 1) begin
      fails++;
      $display("FAIL bp_done: dones=%0d, required 1", done_cnt - dn0);
    end
  endtask

  task automatic test_clamp;
    int base;
    logic [31:0] exp_hi, exp_lo;
`ifdef ACCUM_READER_CLAMP_EN
    exp_hi = 32'd127;
    exp_lo = 32'hFFFF_FF80;
`else
    exp_hi = 32'd1000;
    exp_lo = 32'hFFFF_FE0C;
`endif
    do_reset();
    res_ready_i = 1'b1;
    base = got.size();
    start_tile(8'd1, 8'd2);
    send_psum(32'd1000);
    send_psum(32'hFFFF_FE0C);
    wait_results(base + 2);
    checks++;
    if (got.size() < base + 2 || got[base] !== exp_hi) begin
      fails++;
      $display("FAIL clamp_high: got %0d, required %0d", $signed(got[base]), $signed(exp_hi));
    end
    checks++;
    if (got.size() < base + 2 || got[base+1] !== exp_lo) begin
      fails++;
      $display("FAIL clamp_low: got %0d, required %0d", $signed(got[base+1]), $signed(exp_lo));
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_abort;
    int wr0, rd0, dn0, base;
    do_reset();
    res_ready_i = 1'b1;
    start_tile(8'd3, 8'd1);
    send_psum(32'd1);
    send_psum(32'd2);
    do_reset();
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || res_valid_o !== 1'b0 || psum_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: busy=%0b res_valid=%0b rdy=%0b, required 0/0/0", busy_o, res_valid_o, psum_ready_o);
    end
    @(posedge clk);
    #1;
    wr0 = wr_cnt; rd0 = rd_cnt; dn0 = done_cnt; base = got.size();
    start_tile(8'd3, 8'd1);
    send_psum(32'd7);
    send_psum(32'd8);
    send_psum(32'd9);
    wait_results(base + 1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got.size() != base + 1 || got[base] !== 32'd24) begin
      fails++;
      $display("FAIL abort_result: count=%0d value=%0d, required %0d/24", got.size(), got[base], base + 1);
    end
    checks++;
    if (wr_cnt - wr0 != 3 || rd_cnt - rd0 != 1 || done_cnt - dn0 != 1) begin
      fails++;
      $display("FAIL abort_counts: writes=%0d reads=%0d dones=%0d, required 3/1/1",
               wr_cnt - wr0, rd_cnt - rd0, done_cnt - dn0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_outputs();
    test_backpressure();
    test_clamp();
    test_abort();
    checks++;
    if (excl != 0) begin
      fails++;
      $display("FAIL write_read_exclusive: overlapping cycles=%0d, required 0", excl);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/accum_reader.md
# accum_reader

Sequencer for the output-buffer accumulator. It feeds partial sums from the PIM array into the accumulator's write port and issues the read pulse once per output. It captures the accumulator's registered result one cycle after each read and queues it in a small FIFO behind a valid/ready result stream. It sits between the array psum stream and the peripheral result bus, and is the only driver of the accumulator's write_en/data/read_en inputs.

## Interface
Parameters:
- FIFO_DEPTH, 4: result FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 8: width of the psum and output counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  one-cycle pulse that starts a tile; ignored while busy_o=1.
- num_psum_i  in  CNT_W  partial sums per output; 0 is treated as 1; latched on start.
- num_out_i  in  CNT_W  outputs per tile; latched on start.
- psum_valid_i  in  1  partial sum valid.
- psum_i  in  32  partial sum.
- psum_ready_o  out  1  partial sum accepted when high together with valid.
- acc_write_en_o  out  1  accumulator write enable.
- acc_data_o  out  32  accumulator write data.
- acc_read_en_o  out  1  accumulator read and clear.
- acc_data_i  in  32  accumulator output; valid only in the cycle after acc_read_en_o.
- res_valid_o  out  1  result available.
- res_data_o  out  32  result, FIFO head.
- res_ready_i  in  1  consumer accepts the result.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when a tile completes.

## Operation
States and transitions:
- IDLE → ACCUM on start_i with num_out_i≠0.
- IDLE → DONE on start_i with num_out_i=0.
- ACCUM → READ when the accepted psum count reaches the latched num_psum.
- READ → CAPT when the FIFO is not full; otherwise stay in READ.
- CAPT → ACCUM if more outputs remain.
- CAPT → DONE after the last output.
- DONE → IDLE unconditionally.

Per-state behaviour:
- ACCUM: psum_ready_o=1. acc_write_en_o is psum_valid_i & psum_ready_o, combinational. acc_data_o=psum_i. Gaps in psum_valid_i are allowed.
- READ: acc_read_en_o=1 only in the cycle that exits to CAPT. While stalled on a full FIFO, acc_read_en_o=0 and psum_ready_o=0.
- CAPT: push acc_data_i into the FIFO, after the optional clamp. Increment the output counter. Clear the psum counter.
- DONE: done_o=1.

Rules:
- acc_write_en_o and acc_read_en_o are never high in the same cycle.
- Outside ACCUM, psum_ready_o=0 and acc_write_en_o=0.
- At most one read is in flight. The READ not-full check is sufficient because nothing else pushes between READ and CAPT.
- The FIFO supports a simultaneous push and pop.
- Result order equals output order.
- The FIFO is not flushed on DONE. Results drain independently of the FSM, so a new tile may start while the FIFO is non-empty.
- Arithmetic: counters compare with equality at CNT_W bits. No arithmetic is performed on data except the optional clamp.

## Timing
- Reset: state IDLE, counters 0, FIFO empty. All outputs are 0: psum_ready_o, acc_write_en_o, acc_data_o, acc_read_en_o, res_valid_o, res_data_o, busy_o, done_o.
- Reset mid-operation: same as reset, effective at the next edge. The integration resets the accumulator from the same source, inverted.
- Last psum accepted at cycle t, FIFO not full:
  - acc_read_en_o at t+1.
  - Capture at t+2.
  - res_valid_o at t+3.
- Minimum cycles per output: num_psum+2.
- done_o rises in the cycle after the last CAPT.
- For num_out_i=0: done_o one cycle after start_i.

## Configuration
- ACCUM_READER_CLAMP_EN defined: the captured value is clamped as signed to [-128, 127] and sign-extended to 32 bits before the push.
- ACCUM_READER_CLAMP_EN undefined: the raw 32-bit acc_data_i is pushed.

## Structure
- Package accum_pkg:
  - state enum typedef (IDLE, ACCUM, READ, CAPT, DONE);
  - ACC_W=32;
  - INT8_MIN and INT8_MAX constants.
- Sub-module result_fifo: synchronous FIFO, parameters DEPTH and width. The head is registered, so res_valid_o rises one cycle after the push.

## Test plan
- Reset: assert rst_i for 2 cycles mid-traffic → all outputs 0, busy_o=0.
- Single output: num_psum=3, num_out=1; psums 10, 20, 30 with gaps; accumulator model with zero_point 5 → one result of 65, then done_o pulse. Check acc_write_en_o exactly 3 times and acc_read_en_o exactly once.
- Backpressure: num_out=6, num_psum=1, res_ready_i=0 → 4 results queued; READ stalls with acc_read_en_o=0 and psum_ready_o=0. Raise res_ready_i → results 1..6 arrive in order.
- Zero outputs: start_i with num_out_i=0 → done_o one cycle after start_i; no accumulator activity.
- Clamp: psum 1000 → 127 with the macro, 1000 without. Psum -500 → -128 with the macro.
- Abort: rst_i after 2 of 3 psums → IDLE, FIFO empty. A new start_i then behaves as from fresh reset.
